// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the oscillator / PLL clock generator model.
package clkgen_pkg;

  localparam int OSC_DIV_DEFAULT     = 10;
  localparam int PLL_DIV_DEFAULT     = 4;
  localparam int LOCK_CYCLES_DEFAULT = 16;

  // Number of master-clock cycles the divided clock spends high (floor of half).
  function automatic int hi_len(input int div);
    return div / 2;
  endfunction

  // Counter width able to hold 0..div-1, never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/clk_div.sv
// Integer clock divider with registered output: high for floor(DIV/2) cycles,
// low for the remainder. clr forces the phase back to zero and the output low.
module clk_div
  import clkgen_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic q
);

  localparam int             W    = cnt_width(DIV);
  localparam logic [W-1:0]   HI   = W'(hi_len(DIV));
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;

  if (DIV < 2) begin : g_bad_div
    $error("clk_div: DIV must be >= 2");
  end

  // Phase counter and output flop; the output reflects the phase before it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      q       <= 1'b0;
    end else if (clr) begin
      cnt_reg <= '0;
      q       <= 1'b0;
    end else if (en) begin
      q       <= (cnt_reg < HI);
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/osc_pll_model.sv
// Behavioural stand-in for the internal oscillator plus PLL pair: an oscillator
// divider, a lock-acquisition counter and a PLL divider gated by lock.
module osc_pll_model
  import clkgen_pkg::*;
#(
  parameter int OSC_DIV     = OSC_DIV_DEFAULT,
  parameter int PLL_DIV     = PLL_DIV_DEFAULT,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_en,
  input  logic pll_reset,
  output logic oscout,
  output logic clkout,
  output logic lock
);

  localparam int            LW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  if (OSC_DIV < 2) begin : g_bad_osc_div
    $error("osc_pll_model: OSC_DIV must be >= 2");
  end
  if (PLL_DIV < 2) begin : g_bad_pll_div
    $error("osc_pll_model: PLL_DIV must be >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("osc_pll_model: LOCK_CYCLES must be >= 1");
  end

  logic          osc_q;
  logic          rise;
  logic [LW-1:0] lock_cnt_reg;
  logic          pll_run;

  assign rise = oscout & ~osc_q;
  assign lock = (lock_cnt_reg == LOCK_MAX);

  // The PLL divider stops on the same edge that drops lock, so clkout and lock
  // fall together when pll_reset or osc_en=0 knock the PLL out of lock.
  assign pll_run = lock & ~pll_reset & osc_en;

  clk_div #(.DIV(OSC_DIV)) u_osc_div (
    .clk (clk),
    .rst (rst),
    .en  (osc_en),
    .clr (~osc_en),
    .q   (oscout)
  );

  clk_div #(.DIV(PLL_DIV)) u_pll_div (
    .clk (clk),
    .rst (rst),
    .en  (pll_run),
    .clr (~pll_run),
    .q   (clkout)
  );

  // Delayed copy of oscout for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) osc_q <= 1'b0;
    else     osc_q <= oscout;
  end

  // Lock acquisition: count oscout rises up to LOCK_CYCLES; reset wins over a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_reg <= '0;
    end else if (pll_reset || !osc_en) begin
      lock_cnt_reg <= '0;
    end else if (rise && (lock_cnt_reg != LOCK_MAX)) begin
      lock_cnt_reg <= lock_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_osc_pll_model.sv
// Bench for osc_pll_model: a default instance and an odd-divisor instance share
// stimulus; a cycle model pushes expected outputs into a scoreboard queue that
// is popped after each clock edge, plus targeted timing checks.
module tb_osc_pll_model;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osc_en = 1'b0;
  logic pll_reset = 1'b0;
  logic a_osc, a_clk, a_lock;
  logic b_osc, b_clk, b_lock;

  always #5 clk = ~clk;

  osc_pll_model dut_a (
    .clk(clk), .rst(rst), .osc_en(osc_en), .pll_reset(pll_reset),
    .oscout(a_osc), .clkout(a_clk), .lock(a_lock)
  );

  osc_pll_model #(.OSC_DIV(5), .PLL_DIV(3), .LOCK_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .osc_en(osc_en), .pll_reset(pll_reset),
    .oscout(b_osc), .clkout(b_clk), .lock(b_lock)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Cycle model state, index 0 = default config, 1 = odd config.
  int m_odiv[2] = '{10, 5};
  int m_pdiv[2] = '{4, 3};
  int m_lmax[2] = '{16, 1};
  int m_ocnt[2], m_pcnt[2], m_lcnt[2];
  bit m_osc[2], m_oq[2], m_clk[2];

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } exp_t;
  exp_t sb[$];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ocnt[k] = 0; m_pcnt[k] = 0; m_lcnt[k] = 0;
      m_osc[k] = 0;  m_oq[k] = 0;   m_clk[k] = 0;
    end
  endfunction

  function automatic void model_edge(input bit en, input bit pr);
    for (int k = 0; k < 2; k++) begin
      bit rise_old, lock_old;
      rise_old = m_osc[k] && !m_oq[k];
      lock_old = (m_lcnt[k] == m_lmax[k]);
      m_oq[k]  = m_osc[k];
      if (!en) begin
        m_ocnt[k] = 0; m_osc[k] = 0;
      end else begin
        m_osc[k]  = (m_ocnt[k] < m_odiv[k] / 2);
        m_ocnt[k] = (m_ocnt[k] + 1) % m_odiv[k];
      end
      if (lock_old && !pr && en) begin
        m_clk[k]  = (m_pcnt[k] < m_pdiv[k] / 2);
        m_pcnt[k] = (m_pcnt[k] + 1) % m_pdiv[k];
      end else begin
        m_pcnt[k] = 0; m_clk[k] = 0;
      end
      if (pr || !en) m_lcnt[k] = 0;
      else if (rise_old && m_lcnt[k] < m_lmax[k]) m_lcnt[k]++;
    end
  endfunction

  // One clock: predict, push, wait for the edge, pop and compare.
  task automatic step();
    exp_t e, got_e;
    if (rst) model_reset();
    else     model_edge(osc_en, pll_reset);
    e.a = {m_osc[0], m_clk[0], m_lcnt[0] == m_lmax[0]};
    e.b = {m_osc[1], m_clk[1], m_lcnt[1] == m_lmax[1]};
    sb.push_back(e);
    @(posedge clk);
    #1;
    edge_n++;
    got_e = sb.pop_front();
    check_val("cfg_default", {29'd0, a_osc, a_clk, a_lock}, {29'd0, got_e.a});
    check_val("cfg_odd",     {29'd0, b_osc, b_clk, b_lock}, {29'd0, got_e.b});
  endtask

  initial begin
    model_reset();
    // Reset held 5 clocks with random inputs
    for (int i = 0; i < 5; i++) begin
      osc_en = 1'($urandom); pll_reset = 1'($urandom);
      step();
      check_val("rst_outputs", {29'd0, a_osc, a_clk, a_lock}, 32'd0);
    end
    // Release reset: oscillator and lock acquisition with fixed timing
    osc_en = 1'b1; pll_reset = 1'b0; rst = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 170; i++) begin
      step();
      if (edge_n == 1)   check_val("osc_first_high", {31'd0, a_osc}, 32'd1);
      if (edge_n == 5)   check_val("osc_high_end", {31'd0, a_osc}, 32'd1);
      if (edge_n == 6)   check_val("osc_low_start", {31'd0, a_osc}, 32'd0);
      if (edge_n == 11)  check_val("osc_period", {31'd0, a_osc}, 32'd1);
      if (edge_n == 151) check_val("lock_before", {31'd0, a_lock}, 32'd0);
      if (edge_n == 152) check_val("lock_at_152", {31'd0, a_lock}, 32'd1);
      if (edge_n == 152) check_val("clk_lowlock", {31'd0, a_clk}, 32'd0);
      if (edge_n == 153) check_val("clk_first_hi", {31'd0, a_clk}, 32'd1);
      if (edge_n == 155) check_val("clk_low_ph", {31'd0, a_clk}, 32'd0);
      if (edge_n == 157) check_val("clk_period", {31'd0, a_clk}, 32'd1);
      if (edge_n == 2)   check_val("odd_lock", {31'd0, b_lock}, 32'd1);
      if (edge_n == 3)   check_val("odd_clk_hi", {31'd0, b_clk}, 32'd1);
      if (edge_n == 4)   check_val("odd_clk_lo", {31'd0, b_clk}, 32'd0);
      if (edge_n == 3)   check_val("odd_osc_lo", {31'd0, b_osc}, 32'd0);
    end
    // pll_reset pulse while locked
    pll_reset = 1'b1;
    step();
    check_val("prst_lock", {31'd0, a_lock}, 32'd0);
    check_val("prst_clk", {31'd0, a_clk}, 32'd0);
    pll_reset = 1'b0;
    for (int i = 0; i < 200; i++) step();
    check_val("relock_prst", {31'd0, a_lock}, 32'd1);
    // osc_en drop for 30 clocks
    osc_en = 1'b0;
    step();
    check_val("oscen_off", {29'd0, a_osc, a_clk, a_lock}, 32'd0);
    for (int i = 0; i < 29; i++) step();
    osc_en = 1'b1;
    step();
    check_val("oscen_restart", {31'd0, a_osc}, 32'd1);
    for (int i = 0; i < 200; i++) step();
    check_val("relock_oscen", {31'd0, a_lock}, 32'd1);
    // Asynchronous reset mid-operation clears outputs before the next edge
    rst = 1'b1;
    #1;
    check_val("async_rst", {26'd0, a_osc, a_clk, a_lock, b_osc, b_clk, b_lock}, 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 200; i++) step();
    // Random pll_reset / osc_en activity
    for (int i = 0; i < 300; i++) begin
      pll_reset = ($urandom_range(0, 39) == 0);
      osc_en    = ($urandom_range(0, 49) != 0);
      step();
    end
    check_val("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
